// File: rtl/load_mem_ctrl.sv
// Load memory controller: pops one load, reads the dcache, broadcasts the result on the CDB.
// Latency: 1 cycle pop + N dcache cycles + >=1 BCAST cycle; one load in flight at a time.
// Backpressure: holds dmem_read until dmem_resp, holds cdb_req/data/tag until cdb_grant.
module load_mem_ctrl #(
    parameter int data_width = 16,
    parameter int tag_width  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  lb_valid,
    input  logic [data_width-1:0] lb_addr,
    input  logic [tag_width-1:0]  lb_dest,
    input  logic                  lb_byte,
    output logic                  lb_RE,
    output logic                  dmem_read,
    output logic [data_width-1:0] dmem_address,
    input  logic [data_width-1:0] dmem_rdata,
    input  logic                  dmem_resp,
    output logic                  cdb_req,
    input  logic                  cdb_grant,
    output logic [data_width-1:0] cdb_data,
    output logic [tag_width-1:0]  cdb_tag,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, MEM, BCAST, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [data_width-1:0] addr_r, data_r;
    logic [tag_width-1:0]  tag_r;
    logic                  byte_r;
    logic                  load_en, data_en;
    logic [7:0]            sel_byte;
    logic [data_width-1:0] load_data;

    assign sel_byte  = addr_r[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign load_data = byte_r ? {{(data_width-8){1'b0}}, sel_byte} : dmem_rdata;

    always_comb begin
        state_nxt = state;
        lb_RE     = 1'b0;
        load_en   = 1'b0;
        data_en   = 1'b0;
        case (state)
            IDLE: begin
                if (lb_valid && !flush) begin
                    // gated by reset so the pop strobe is quiet while reset is held
                    lb_RE     = reset_n;
                    load_en   = 1'b1;
                    state_nxt = MEM;
                end
            end
            MEM: begin
                if (flush) begin
                    state_nxt = dmem_resp ? IDLE : DRAIN;
                end else if (dmem_resp) begin
                    data_en   = 1'b1;
                    state_nxt = BCAST;
                end
            end
            BCAST: begin
                if (cdb_grant || flush) state_nxt = IDLE;
            end
            DRAIN: begin
                if (dmem_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= '0;
            tag_r  <= '0;
            byte_r <= 1'b0;
        end else if (load_en) begin
            addr_r <= lb_addr;
            tag_r  <= lb_dest;
            byte_r <= lb_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     data_r <= '0;
        else if (data_en) data_r <= load_data;
    end

    // DRAIN keeps the read asserted: the dcache transaction cannot be cancelled
    assign dmem_read    = (state == MEM) || (state == DRAIN);
    assign dmem_address = {addr_r[data_width-1:1], 1'b0};
    assign cdb_req      = (state == BCAST);
    assign cdb_data     = data_r;
    assign cdb_tag      = tag_r;
    assign busy         = (state != IDLE);

endmodule

// File: doc/load_mem_ctrl.md
LOAD_MEM_CTRL -- requirements
Module: load_mem_ctrl

Interface
REQ-001 The module SHALL have parameter data_width, default 16, the width of addresses and data words.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The module SHALL have port flush, input, 1 bit, a misprediction flush that abandons the in-flight load.
REQ-005 The module SHALL have port lb_valid, input, 1 bit, meaning the load buffer head entry has a resolved address.
REQ-006 The module SHALL have port lb_addr, input, data_width bits, the effective address from the load buffer.
REQ-007 The module SHALL have port lb_dest, input, lc3b_rob_addr, the ROB tag of the head load.
REQ-008 The module SHALL have port lb_byte, input, 1 bit, meaning LDB (byte load) rather than LDR.
REQ-009 The module SHALL have port lb_RE, output, 1 bit, a one-cycle pop strobe to the load buffer (its RE).
REQ-010 The module SHALL have port dmem_read, output, 1 bit, the dcache read request.
REQ-011 The module SHALL have port dmem_address, output, data_width bits, the dcache address.
REQ-012 The module SHALL have port dmem_rdata, input, data_width bits, the dcache read data.
REQ-013 The module SHALL have port dmem_resp, input, 1 bit, meaning dcache data is valid this cycle.
REQ-014 The module SHALL have port cdb_req, output, 1 bit, a request for a CDB broadcast slot.
REQ-015 The module SHALL have port cdb_grant, input, 1 bit, meaning the arbiter grants the CDB this cycle.
REQ-016 The module SHALL have port cdb_data, output, data_width bits, the load result for broadcast.
REQ-017 The module SHALL have port cdb_tag, output, lc3b_rob_addr, the ROB tag for broadcast.
REQ-018 The module SHALL have port busy, output, 1 bit, meaning the state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, MEM, BCAST and DRAIN, and all outputs SHALL be functions of state and registers only (Moore), except lb_RE.
REQ-020 In IDLE, the block SHALL behave as follows when lb_valid=1 and flush=0:
- lb_RE=1 for exactly that cycle (combinational).
- lb_addr, lb_dest and lb_byte are latched into addr_r, tag_r and byte_r.
- The next state is MEM.
REQ-021 In IDLE with flush=1, lb_RE SHALL be 0, nothing SHALL be latched, and the state SHALL remain IDLE.
REQ-022 In MEM, dmem_read SHALL be 1 and dmem_address SHALL be addr_r with bit 0 forced to 0.
REQ-023 In MEM, dmem_read SHALL hold until dmem_resp and the address SHALL remain stable throughout.
REQ-024 In MEM, on dmem_resp=1 with flush=0, the block SHALL latch the result into data_r and move to BCAST:
- Word load: data_r = dmem_rdata.
- Byte load: data_r = zero-extended dmem_rdata[15:8] if addr_r[0]=1, else zero-extended dmem_rdata[7:0].
REQ-025 In BCAST, cdb_req SHALL be 1, cdb_data SHALL equal data_r and cdb_tag SHALL equal tag_r, all held until cdb_grant=1, after which the next state is IDLE.
REQ-026 A new pop SHALL occur no earlier than the cycle after the grant, so minimum load latency is 1 cycle (pop) + N (dcache) + 1 (BCAST), and at most one load is in flight.
REQ-027 Flush in MEM with dmem_resp=0 SHALL move the state to DRAIN, because the dcache read cannot be aborted.
REQ-028 In DRAIN, dmem_read SHALL stay 1 with the same address, and on dmem_resp the data SHALL be discarded and the state SHALL go to IDLE with no broadcast.
REQ-029 Flush in MEM coincident with dmem_resp SHALL send the state to IDLE and discard the data.
REQ-030 Flush in BCAST SHALL send the state to IDLE, dropping cdb_req from the next cycle; a grant in the same cycle still completes the broadcast.
REQ-031 Flush in DRAIN SHALL have no additional effect.
REQ-032 cdb_data, cdb_tag and dmem_address SHALL be don't-care while their qualifying strobe is 0, but implementation SHALL drive them from the registers.
REQ-033 Outputs other than lb_RE SHALL be glitch-free register or state decodes.

Reset
REQ-034 reset_n=0 SHALL immediately force state IDLE and clear addr_r, tag_r, byte_r and data_r to 0, giving lb_RE=0, dmem_read=0, cdb_req=0 and busy=0.
REQ-035 Reset mid-MEM SHALL drop dmem_read at once; the dcache is reset in the same domain, so no drain is required.
REQ-036 Operation SHALL resume on the first rising edge after reset_n deasserts.

Verification
REQ-037 Word load: lb_valid=1, addr=0x1235, dest=3, byte=0; dcache resp after 2 cycles with 0xBEEF -> lb_RE pulses once, dmem_address=0x1234, cdb_req with data=0xBEEF, tag=3; grant -> IDLE.
REQ-038 Byte load: addr=0x2001, byte=1, rdata=0xA55A -> cdb_data=0x00A5; addr=0x2000 -> cdb_data=0x005A.
REQ-039 Flush during MEM: flush on the cycle after the pop, resp 3 cycles later -> DRAIN, dmem_read held until resp, no cdb_req, then IDLE and the next lb_valid is popped.
REQ-040 CDB backpressure: cdb_grant low for 4 cycles -> cdb_req, cdb_data and cdb_tag are stable for all 4 cycles, lb_RE stays 0, and a single broadcast occurs on the grant.
REQ-041 Flush in IDLE with lb_valid=1 -> no lb_RE; reset_n low during BCAST -> all outputs are 0 asynchronously.
REQ-042 Back-to-back loads with lb_valid held high -> the second lb_RE occurs exactly one cycle after the first grant.
